// File: rtl/store_wbuffer.sv
// Post-commit store write buffer: speculative stores, in-order commit,
// in-order drain to the D-cache, and byte-granular load forwarding.
package store_wbuffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [2:0]  msize;
        logic [7:0]  strobe;
        logic [31:0] addr;
        logic [63:0] data;
    } wbuffer_wreq_t;

    typedef struct packed {
        logic valid;
    } wbuffer_creq_t;

    typedef struct packed {
        logic [31:0] addr;
    } wbuffer_rreq_t;

    typedef struct packed {
        logic [7:0]      valid;
        logic [7:0][7:0] data;
    } wbuffer_rresp_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  msize;
        logic [7:0]  strobe;
        logic [31:0] addr;
        logic [63:0] data;
    } wbuffer_entry_t;

endpackage

module store_wbuffer
    import store_wbuffer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  wbuffer_wreq_t  wreq,
    output logic           wreq_ready,
    input  wbuffer_creq_t  creq,
    input  logic           flush,
    input  wbuffer_rreq_t  rreq,
    output wbuffer_rresp_t rresp,
    output logic           dreq_valid,
    output logic [31:0]    dreq_addr,
    output logic [2:0]     dreq_msize,
    output logic [7:0]     dreq_strobe,
    output logic [63:0]    dreq_data,
    input  logic           dreq_ready,
    output logic           empty
);

    wbuffer_entry_t entries [DEPTH];

    logic [PTR_W:0]   head, cmt, tail;
    logic [PTR_W:0]   head_nxt, cmt_nxt, tail_nxt;
    logic [PTR_W:0]   span;
    logic [PTR_W-1:0] head_idx, tail_idx;
    logic [PTR_W-1:0] fwd_idx, off;
    logic [DEPTH-1:0] disc;
    logic             full, do_enq, do_cmt, do_drn;
    wbuffer_entry_t   fwd_e;
    logic             unused_rreq;

    assign head_idx = head[PTR_W-1:0];
    assign tail_idx = tail[PTR_W-1:0];

    assign full = (head[PTR_W] != tail[PTR_W]) && (head_idx == tail_idx);
    assign wreq_ready = !full;
    assign empty = (head == tail);
    assign dreq_valid = (head != cmt);

    assign dreq_addr   = entries[head_idx].addr;
    assign dreq_msize  = entries[head_idx].msize;
    assign dreq_strobe = entries[head_idx].strobe;
    assign dreq_data   = entries[head_idx].data;

    assign do_enq = wreq.valid && !full && !flush;
    assign do_cmt = creq.valid && (cmt != tail);
    assign do_drn = dreq_valid && dreq_ready;

    assign head_nxt = head + {{PTR_W{1'b0}}, do_drn};
    assign cmt_nxt  = cmt + {{PTR_W{1'b0}}, do_cmt};
    assign tail_nxt = flush ? cmt_nxt : tail + {{PTR_W{1'b0}}, do_enq};

    // Entries in [cmt_nxt, tail) are the ones a flush throws away.
    assign span = tail - cmt_nxt;

    always_comb begin
        disc = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - cmt_nxt[PTR_W-1:0];
            disc[i] = flush && ({1'b0, off} < span);
        end
    end

    // Walk oldest to youngest so the youngest matching byte wins.
    always_comb begin
        rresp   = '0;
        fwd_idx = '0;
        fwd_e   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_idx + PTR_W'(k);
            fwd_e   = entries[fwd_idx];
            if (fwd_e.valid && fwd_e.addr[31:3] == rreq.addr[31:3]) begin
                for (int b = 0; b < 8; b++) begin
                    if (fwd_e.strobe[b]) begin
                        rresp.valid[b] = 1'b1;
                        rresp.data[b]  = fwd_e.data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign unused_rreq = ^rreq.addr[2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            head <= head_nxt;
            cmt  <= cmt_nxt;
            tail <= tail_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (disc[i]) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (do_drn) begin
                entries[head_idx].valid <= 1'b0;
            end
            if (do_enq) begin
                entries[tail_idx].valid  <= 1'b1;
                entries[tail_idx].msize  <= wreq.msize;
                entries[tail_idx].strobe <= wreq.strobe;
                entries[tail_idx].addr   <= wreq.addr;
                entries[tail_idx].data   <= wreq.data;
            end
        end
    end

endmodule

// File: tb/tb_store_wbuffer.sv
// Self-checking bench for store_wbuffer against a queue-based model.
module tb_store_wbuffer;
    import store_wbuffer_pkg::*;

    localparam int DEPTH = 8;

    logic           clk;
    logic           reset;
    wbuffer_wreq_t  wreq;
    logic           wreq_ready;
    wbuffer_creq_t  creq;
    logic           flush;
    wbuffer_rreq_t  rreq;
    wbuffer_rresp_t rresp;
    logic           dreq_valid;
    logic [31:0]    dreq_addr;
    logic [2:0]     dreq_msize;
    logic [7:0]     dreq_strobe;
    logic [63:0]    dreq_data;
    logic           dreq_ready;
    logic           empty;

    int n_checks = 0;
    int n_fail = 0;

    wbuffer_entry_t q[$];
    int ncmt = 0;

    store_wbuffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wreq(wreq), .wreq_ready(wreq_ready),
        .creq(creq), .flush(flush),
        .rreq(rreq), .rresp(rresp),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_msize(dreq_msize), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dreq_ready(dreq_ready),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wbuffer_wreq_t mk_wreq(logic [31:0] a, logic [7:0] s,
                                              logic [63:0] d);
        wbuffer_wreq_t r;
        r.valid = 1'b1;
        r.msize = 3'd3;
        r.strobe = s;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    function automatic wbuffer_wreq_t rnd_wreq();
        wbuffer_wreq_t r;
        r.valid = 1'b1;
        r.msize = 3'($urandom_range(0, 3));
        r.strobe = 8'($urandom);
        r.addr = 32'h4000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
        r.data = {$urandom, $urandom};
        return r;
    endfunction

    function automatic wbuffer_entry_t mk_entry(wbuffer_wreq_t w);
        wbuffer_entry_t e;
        e.valid = 1'b1;
        e.msize = w.msize;
        e.strobe = w.strobe;
        e.addr = w.addr;
        e.data = w.data;
        return e;
    endfunction

    // Youngest store in program order owns each byte lane.
    function automatic wbuffer_rresp_t mdl_fwd(logic [31:0] a);
        wbuffer_rresp_t r;
        r = '0;
        foreach (q[j]) begin
            if (q[j].addr[31:3] == a[31:3]) begin
                for (int b = 0; b < 8; b++) begin
                    if (q[j].strobe[b]) begin
                        r.valid[b] = 1'b1;
                        r.data[b] = q[j].data[8*b +: 8];
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic mdl_update();
        bit en, cm, dr;
        en = wreq.valid && (q.size() < DEPTH) && !flush;
        cm = creq.valid && (ncmt < q.size());
        dr = (ncmt > 0) && dreq_ready;
        if (dr) begin
            q.delete(0);
            ncmt--;
        end
        if (cm) ncmt++;
        if (flush) begin
            while (q.size() > ncmt) q.delete(q.size() - 1);
        end
        if (en) q.push_back(mk_entry(wreq));
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    task automatic idle();
        wreq = '0;
        creq = '0;
        flush = 1'b0;
        dreq_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        q.delete();
        ncmt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        wreq = '0;
        flush = 1'b0;
        creq.valid = 1'b1;
        dreq_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && q.size() > 0; i++) tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rreq = '0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (wreq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wreq_ready got=%b exp=1", wreq_ready);
        end
        n_checks++;
        if (dreq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dreq_valid got=%b exp=0", dreq_valid);
        end
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_empty got=%b exp=1", empty);
        end
        n_checks++;
        if (rresp !== '0) begin
            n_fail++;
            $display("FAIL reset_rresp got=%h exp=0", rresp);
        end
        do_reset();
    endtask

    task automatic test_in_order();
        idle();
        wreq = mk_wreq(32'h1000, 8'hFF, 64'h1122334455667788);
        tick();
        wreq = mk_wreq(32'h1008, 8'h0F, 64'h0000_0000_CAFE_F00D);
        tick();
        wreq = '0;
        tick();
        n_checks++;
        if (dreq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL order_uncommitted dreq_valid got=%b exp=0", dreq_valid);
        end
        creq.valid = 1'b1;
        dreq_ready = 1'b1;
        tick();
        n_checks++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h1000 ||
            dreq_data !== 64'h1122334455667788 || dreq_strobe !== 8'hFF) begin
            n_fail++;
            $display("FAIL order_first got v=%b a=%h d=%h s=%h exp v=1 a=1000 d=1122334455667788 s=ff",
                     dreq_valid, dreq_addr, dreq_data, dreq_strobe);
        end
        tick();
        creq.valid = 1'b0;
        n_checks++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h1008 || dreq_strobe !== 8'h0F) begin
            n_fail++;
            $display("FAIL order_second got v=%b a=%h s=%h exp v=1 a=1008 s=0f",
                     dreq_valid, dreq_addr, dreq_strobe);
        end
        tick();
        n_checks++;
        if (empty !== 1'b1 || dreq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL order_empty got e=%b v=%b exp e=1 v=0", empty, dreq_valid);
        end
        idle();
    endtask

    task automatic test_forward();
        wbuffer_rresp_t exp_r;
        idle();
        wreq = mk_wreq(32'h2000, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        tick();
        wreq = mk_wreq(32'h2000, 8'h03, 64'h12345678_0000CCDD);
        rreq.addr = 32'h2004;
        #1;
        exp_r = mdl_fwd(32'h2004);
        n_checks++;
        if (rresp.valid !== 8'h0F || rresp !== exp_r) begin
            n_fail++;
            $display("FAIL fwd_not_yet_enq got=%h exp=%h", rresp, exp_r);
        end
        tick();
        wreq = '0;
        #1;
        n_checks++;
        if (rresp.valid !== 8'h0F || rresp.data[3:0] !== 32'hBBBBCCDD) begin
            n_fail++;
            $display("FAIL fwd_priority got v=%h d=%h exp v=0f d=bbbbccdd",
                     rresp.valid, rresp.data[3:0]);
        end
        n_checks++;
        if (rresp.data[7:4] !== 32'h0) begin
            n_fail++;
            $display("FAIL fwd_unmasked got=%h exp=0", rresp.data[7:4]);
        end
        rreq.addr = 32'h3000;
        #1;
        n_checks++;
        if (rresp !== '0) begin
            n_fail++;
            $display("FAIL fwd_miss got=%h exp=0", rresp);
        end
        drain_all();
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_cleanup_empty got=%b exp=1", empty);
        end
    endtask

    task automatic test_full();
        int drained;
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            wreq = rnd_wreq();
            tick();
        end
        n_checks++;
        if (wreq_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready got=%b exp=0", wreq_ready);
        end
        wreq = mk_wreq(32'h7777_7000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        tick();
        wreq = '0;
        creq.valid = 1'b1;
        tick();
        creq.valid = 1'b0;
        dreq_ready = 1'b1;
        n_checks++;
        if (wreq_ready !== 1'b0 || dreq_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_before_free got r=%b v=%b exp r=0 v=1", wreq_ready, dreq_valid);
        end
        tick();
        dreq_ready = 1'b0;
        n_checks++;
        if (wreq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after_drain got=%b exp=1", wreq_ready);
        end
        drained = 0;
        creq.valid = 1'b1;
        dreq_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && !empty; i++) begin
            if (dreq_valid) begin
                n_checks++;
                if (q.size() == 0 || dreq_addr !== q[0].addr || dreq_data !== q[0].data) begin
                    n_fail++;
                    $display("FAIL full_drain_data got a=%h d=%h", dreq_addr, dreq_data);
                end
                drained++;
            end
            tick();
        end
        idle();
        n_checks++;
        if (drained != DEPTH - 1) begin
            n_fail++;
            $display("FAIL full_drop_count got=%0d exp=%0d", drained, DEPTH - 1);
        end
    endtask

    task automatic test_flush();
        idle();
        wreq = mk_wreq(32'h5000, 8'hFF, 64'h5000_5000_5000_5000);
        tick();
        wreq = mk_wreq(32'h5008, 8'hFF, 64'h5008_5008_5008_5008);
        tick();
        wreq = mk_wreq(32'h5010, 8'hFF, 64'h5010_5010_5010_5010);
        tick();
        wreq = '0;
        creq.valid = 1'b1;
        tick();
        flush = 1'b1;
        wreq = mk_wreq(32'h5018, 8'hFF, 64'h5018_5018_5018_5018);
        tick();
        idle();
        rreq.addr = 32'h5010;
        #1;
        n_checks++;
        if (rresp.valid !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_probe_discarded got=%h exp=00", rresp.valid);
        end
        rreq.addr = 32'h5018;
        #1;
        n_checks++;
        if (rresp.valid !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_wreq_dropped got=%h exp=00", rresp.valid);
        end
        rreq.addr = 32'h5008;
        #1;
        n_checks++;
        if (rresp.valid !== 8'hFF || rresp.data !== 64'h5008_5008_5008_5008) begin
            n_fail++;
            $display("FAIL flush_probe_kept got v=%h d=%h exp v=ff d=5008500850085008",
                     rresp.valid, rresp.data);
        end
        dreq_ready = 1'b1;
        n_checks++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h5000) begin
            n_fail++;
            $display("FAIL flush_drain0 got v=%b a=%h exp v=1 a=5000", dreq_valid, dreq_addr);
        end
        tick();
        n_checks++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h5008) begin
            n_fail++;
            $display("FAIL flush_drain1 got v=%b a=%h exp v=1 a=5008", dreq_valid, dreq_addr);
        end
        tick();
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_tail_eq_cmt got empty=%b exp=1", empty);
        end
        idle();
    endtask

    task automatic test_wrap();
        wbuffer_wreq_t st[20];
        wbuffer_rresp_t exp_r;
        int idx, got, cyc;
        bit acc;
        for (int i = 0; i < 20; i++) begin
            st[i] = mk_wreq(32'h6000 + 32'(i * 8), 8'($urandom), {$urandom, $urandom});
        end
        idle();
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 20 && cyc < 300) begin
            wreq = (idx < 20) ? st[idx] : '0;
            creq.valid = 1'b1;
            dreq_ready = cyc[0];
            rreq.addr = 32'h6000 + 32'($urandom_range(0, 23) * 8);
            #1;
            if (dreq_valid && dreq_ready) begin
                n_checks++;
                if (dreq_addr !== st[got].addr || dreq_data !== st[got].data ||
                    dreq_strobe !== st[got].strobe) begin
                    n_fail++;
                    $display("FAIL wrap_drain_%0d got a=%h d=%h exp a=%h d=%h",
                             got, dreq_addr, dreq_data, st[got].addr, st[got].data);
                end
                got++;
            end
            exp_r = mdl_fwd(rreq.addr);
            n_checks++;
            if (rresp !== exp_r) begin
                n_fail++;
                $display("FAIL wrap_fwd a=%h got=%h exp=%h", rreq.addr, rresp, exp_r);
            end
            acc = wreq.valid && wreq_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        idle();
        n_checks++;
        if (got != 20 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_complete got drained=%0d empty=%b exp 20 1", got, empty);
        end
    endtask

    task automatic test_random();
        wbuffer_rresp_t exp_r;
        idle();
        for (int c = 0; c < 400; c++) begin
            wreq = ($urandom_range(0, 1) == 1) ? rnd_wreq() : '0;
            creq.valid = ($urandom_range(0, 9) < 4);
            flush = ($urandom_range(0, 19) == 0);
            dreq_ready = ($urandom_range(0, 1) == 1);
            rreq.addr = 32'h4000 + 32'($urandom_range(0, 8) * 8) + 32'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (wreq_ready !== (q.size() < DEPTH) || empty !== (q.size() == 0) ||
                dreq_valid !== (ncmt > 0)) begin
                n_fail++;
                $display("FAIL rand_status c=%0d got r=%b e=%b v=%b exp size=%0d ncmt=%0d",
                         c, wreq_ready, empty, dreq_valid, q.size(), ncmt);
            end
            if (ncmt > 0) begin
                n_checks++;
                if (dreq_addr !== q[0].addr || dreq_data !== q[0].data ||
                    dreq_strobe !== q[0].strobe || dreq_msize !== q[0].msize) begin
                    n_fail++;
                    $display("FAIL rand_dreq c=%0d got a=%h d=%h exp a=%h d=%h",
                             c, dreq_addr, dreq_data, q[0].addr, q[0].data);
                end
            end
            exp_r = mdl_fwd(rreq.addr);
            n_checks++;
            if (rresp !== exp_r) begin
                n_fail++;
                $display("FAIL rand_fwd c=%0d got=%h exp=%h", c, rresp, exp_r);
            end
            tick();
        end
        drain_all();
    endtask

    task automatic test_backpressure_reset();
        wbuffer_entry_t exp_e;
        idle();
        wreq = rnd_wreq();
        tick();
        wreq = rnd_wreq();
        tick();
        wreq = '0;
        creq.valid = 1'b1;
        tick();
        creq.valid = 1'b0;
        exp_e = q[0];
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (dreq_valid !== 1'b1 || dreq_addr !== exp_e.addr || dreq_data !== exp_e.data ||
                dreq_strobe !== exp_e.strobe || dreq_msize !== exp_e.msize) begin
                n_fail++;
                $display("FAIL bp_stable_%0d got v=%b a=%h d=%h exp a=%h d=%h",
                         i, dreq_valid, dreq_addr, dreq_data, exp_e.addr, exp_e.data);
            end
            tick();
        end
        rreq.addr = exp_e.addr;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dreq_valid !== 1'b0 || empty !== 1'b1 || wreq_ready !== 1'b1 || rresp !== '0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b e=%b r=%b f=%h exp 0 1 1 0",
                     dreq_valid, empty, wreq_ready, rresp);
        end
        q.delete();
        ncmt = 0;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (dreq_valid !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset got v=%b e=%b exp 0 1", dreq_valid, empty);
        end
    endtask

    initial begin
        reset = 1'b0;
        rreq = '0;
        idle();
        test_reset();
        test_in_order();
        test_forward();
        test_full();
        test_flush();
        test_wrap();
        test_random();
        test_backpressure_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_wbuffer.md
Name: store_wbuffer

Overview:
Post-commit store write buffer between the memory stage and the D-cache. It accepts speculative stores as wbuffer_wreq_t and marks them committed, oldest first, on wbuffer_creq_t. Committed stores drain in program order to the D-cache over a valid/ready port. Loads probe it (wbuffer_rreq_t) and receive byte-granular forwarded data (wbuffer_rresp_t).

Parameters:
DEPTH, 8, number of entries; power of two, ≥2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wreq  in  wbuffer_wreq_t (108: valid 1, msize 3, strobe 8, addr 32, data 64)  store enqueue; wreq.valid qualifies
wreq_ready  out  1  buffer not full
creq  in  wbuffer_creq_t (1)  commit oldest uncommitted entry
flush  in  1  discard all uncommitted entries
rreq  in  wbuffer_rreq_t (32)  load probe address
rresp  out  wbuffer_rresp_t (72: valid strobe 8, data 8×8)  forwarded bytes
dreq_valid  out  1  committed entry available to drain
dreq_addr  out  32  drain address
dreq_msize  out  3  drain size
dreq_strobe  out  8  drain byte strobe
dreq_data  out  64  drain data
dreq_ready  in  1  D-cache accepts drain
empty  out  1  no entries, committed or not

Behaviour:
- Storage: circular array of DEPTH wbuffer_entry_t. Pointers head (oldest), cmt (first uncommitted), tail (next free), each PTR_W+1 bits with wrap bit. Order invariant: head ≤ cmt ≤ tail.
- Reset (async): head=cmt=tail=0; all entry valid bits 0. Resulting outputs: wreq_ready=1, dreq_valid=0, empty=1, rresp=0.
- Derived signals: count=tail-head; ncommitted=cmt-head.
- wreq_ready = (count != DEPTH). It uses registered state only, so a same-cycle drain does not free a slot until the next cycle.
- Enqueue: when wreq.valid && wreq_ready && !flush, the entry is written at tail with valid=1 and tail increments, wrapping modulo DEPTH. wreq.valid while full: store is dropped; the upstream stage must hold it.
- Commit: when creq.valid && cmt != tail (registered), cmt increments. Commit acts only on entries present at the start of the cycle. creq with nothing uncommitted is ignored.
- Drain: dreq_valid = (head != cmt). dreq_* come combinationally from entry[head]. On dreq_valid && dreq_ready, entry[head].valid clears and head increments. dreq_* stay stable while dreq_valid && !dreq_ready.
- Flush: after any same-cycle commit is applied, tail ← new cmt and the valid bits of discarded entries clear. A wreq in the flush cycle is ignored. Drain proceeds normally in the same cycle.
- Simultaneous enqueue + commit + drain in one cycle is legal; each pointer updates independently. The full case is handled by the wreq_ready rule.
- Forwarding is combinational and has zero latency. For each byte lane i (0..7), consider valid entries e where e.addr[31:3]==rreq.addr[31:3] and e.strobe[i]=1. The youngest such entry (closest to tail, committed or not) supplies rresp.data[i], and rresp.valid[i]=1. With no match, valid[i]=0 and data[i]=0.
- Forwarding sees registered state. An entry draining this cycle is still forwarded; an entry enqueued this cycle is not.
- empty = (head == tail).
- Reset asserted mid-drain: all state clears immediately, dreq_valid drops asynchronously, and no partial state survives.

Test Plan:
- Enqueue addr 0x1000 strobe 0xFF data 0x1122334455667788, then addr 0x1008 strobe 0x0F, with no creq → dreq_valid stays 0. Two creq pulses with dreq_ready=1 → drains 0x1000 then 0x1008 in order; empty=1 afterwards.
- Forwarding priority: enqueue 0x2000 strobe 0x0F data 0xAAAAAAAA_BBBBBBBB, then 0x2000 strobe 0x03 data 0x..._0000CCDD. Probe rreq.addr=0x2004 → rresp.valid=0x0F, bytes[1:0]=DD,CC, bytes[3:2]=BB,BB. Probe 0x3000 → valid=0.
- Full: 8 enqueues, none committed → wreq_ready=0 and a 9th wreq is dropped (count stays 8). Commit 1 and drain with dreq_ready=1 → wreq_ready=1 the following cycle.
- Flush: 3 entries with 1 committed; assert flush together with creq and a new wreq → 2 committed entries remain, the wreq is dropped, tail=cmt. A probe of the flushed entry's address misses.
- Wrap-around: stream 20 stores, each committed one cycle after enqueue, with dreq_ready toggling 1/0 → all 20 drain in order with correct data and no duplicates.
- Backpressure and reset: hold dreq_ready=0 for 5 cycles → dreq_* stable. Assert reset mid-hold → dreq_valid=0, empty=1, wreq_ready=1 with no clock edge required.
